riscv_core_reorder_buffer: RTL and testbench

16-entry in-order-commit reorder buffer for the in-order-issue / out-of-order-writeback core. It sits between issue/writeback and the register file.
- Issue allocates one slot per instruction; the scoreboard records that slot against the destination register.
- Writeback fills the slot with its result.
- The head commits in program order, driving the register-file write and the scoreboard's pending-clear (`rob_commit_wen` / `rob_commit_slot`).
- Two read ports supply results to the decode bypass mux for registers whose scoreboard latency has reached zero.

---
 rtl/riscv_core_reorder_buffer_if.sv | 45 ++++
 rtl/riscv_core_reorder_buffer.sv | 122 ++++++++++++
 tb/tb_riscv_core_reorder_buffer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_reorder_buffer_if.sv
// riscv_core_reorder_buffer_if
//   Bundles the reorder-buffer traffic into one interface. Issue, writeback,
//   bypass and commit all travel on it.
//   master : issue/writeback/decode side. It drives alloc, fill and bypass
//            addresses, and it sees grants, bypass data and commits.
//   slave  : the reorder buffer itself.
interface riscv_core_reorder_buffer_if;
    logic        rob_alloc_req_val;
    logic        rob_alloc_req_rdy;
    logic        rob_alloc_req_wen;
    logic [4:0]  rob_alloc_req_preg;
    logic [3:0]  rob_alloc_resp_slot;
    logic        rob_fill_val;
    logic [3:0]  rob_fill_slot;
    logic [31:0] rob_fill_data;
    logic [3:0]  rob_src0_slot;
    logic [3:0]  rob_src1_slot;
    logic [31:0] rob_src0_data;
    logic [31:0] rob_src1_data;
    logic        rob_commit_wen;
    logic [3:0]  rob_commit_slot;
    logic        rob_commit_rf_wen;
    logic [4:0]  rob_commit_rf_waddr;
    logic [31:0] rob_commit_data;

    modport master (
        output rob_alloc_req_val, rob_alloc_req_wen, rob_alloc_req_preg,
        output rob_fill_val, rob_fill_slot, rob_fill_data,
        output rob_src0_slot, rob_src1_slot,
        input  rob_alloc_req_rdy, rob_alloc_resp_slot,
        input  rob_src0_data, rob_src1_data,
        input  rob_commit_wen, rob_commit_slot, rob_commit_rf_wen,
        input  rob_commit_rf_waddr, rob_commit_data
    );

    modport slave (
        input  rob_alloc_req_val, rob_alloc_req_wen, rob_alloc_req_preg,
        input  rob_fill_val, rob_fill_slot, rob_fill_data,
        input  rob_src0_slot, rob_src1_slot,
        output rob_alloc_req_rdy, rob_alloc_resp_slot,
        output rob_src0_data, rob_src1_data,
        output rob_commit_wen, rob_commit_slot, rob_commit_rf_wen,
        output rob_commit_rf_waddr, rob_commit_data
    );
endinterface

// File: rtl/riscv_core_reorder_buffer.sv
// riscv_core_reorder_buffer
//   16-entry reorder buffer with in-order commit. It sits between
//   issue/writeback and the register file.
//
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-low
//     rob   : riscv_core_reorder_buffer_if.slave, which carries:
//               alloc request/grant
//               writeback fill
//               two bypass read ports
//               head commit to the register file
//
//   Optional macro RISCV_ROB_SAME_CYCLE_COMMIT_EN: a fill that targets a
//   valid head commits in the same cycle. The fill data goes straight to
//   the commit port.
module riscv_core_reorder_buffer (
    input  logic                        clk,
    input  logic                        reset,
    riscv_core_reorder_buffer_if.slave  rob
);
    localparam int DEPTH = 16;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] finished_q, finished_d;
    logic [DEPTH-1:0] wen_q;
    logic [4:0]       preg_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       head_q, head_d;
    logic [3:0]       tail_q, tail_d;
    logic [4:0]       count_q, count_d;

    logic             alloc_fire;
    logic             fill_hit;
    logic             commit_fire;
    logic [31:0]      commit_data;

    // Ready looks only at registered occupancy. A slot freed by a commit
    // this cycle can be allocated from the next cycle onward.
    assign rob.rob_alloc_req_rdy   = (count_q != 5'd16);
    assign rob.rob_alloc_resp_slot = tail_q;
    assign alloc_fire = rob.rob_alloc_req_val && rob.rob_alloc_req_rdy;
    assign fill_hit   = rob.rob_fill_val && valid_q[rob.rob_fill_slot];

`ifdef RISCV_ROB_SAME_CYCLE_COMMIT_EN
    logic fill_head;
    assign fill_head   = fill_hit && (rob.rob_fill_slot == head_q);
    assign commit_fire = valid_q[head_q] && (finished_q[head_q] || fill_head);
    assign commit_data = fill_head ? rob.rob_fill_data : data_q[head_q];
`else
    assign commit_fire = valid_q[head_q] && finished_q[head_q];
    assign commit_data = data_q[head_q];
`endif

    assign rob.rob_commit_wen      = commit_fire;
    assign rob.rob_commit_slot     = commit_fire ? head_q : 4'd0;
    assign rob.rob_commit_rf_wen   = commit_fire && wen_q[head_q];
    assign rob.rob_commit_rf_waddr = commit_fire ? preg_q[head_q] : 5'd0;
    assign rob.rob_commit_data     = commit_fire ? commit_data : 32'd0;

    // The read ports see stored state only. A fill becomes visible here
    // one cycle after it is written.
    assign rob.rob_src0_data = data_q[rob.rob_src0_slot];
    assign rob.rob_src1_data = data_q[rob.rob_src1_slot];

    // Alloc and commit never hit the same slot. A commit needs count >= 1
    // and an alloc needs count <= 15, so head != tail whenever both fire.
    // Commit is applied after fill so that a fill landing on the retiring
    // head cannot leave a stale finished bit behind.
    always_comb begin
        valid_d    = valid_q;
        finished_d = finished_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (fill_hit) begin
            finished_d[rob.rob_fill_slot] = 1'b1;
        end
        if (commit_fire) begin
            valid_d[head_q]    = 1'b0;
            finished_d[head_q] = 1'b0;
            head_d             = head_q + 4'd1;
        end
        if (alloc_fire) begin
            valid_d[tail_q]    = 1'b1;
            finished_d[tail_q] = 1'b0;
            tail_d             = tail_q + 4'd1;
        end
        case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            finished_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            finished_q <= finished_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Payload storage has no reset. Entries are guarded by valid_q.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            wen_q[tail_q]  <= rob.rob_alloc_req_wen;
            preg_q[tail_q] <= rob.rob_alloc_req_preg;
        end
        if (fill_hit) begin
            data_q[rob.rob_fill_slot] <= rob.rob_fill_data;
        end
    end
endmodule

// File: tb/tb_riscv_core_reorder_buffer.sv
`timescale 1ns/1ps
module tb_riscv_core_reorder_buffer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    riscv_core_reorder_buffer_if bus();
    riscv_core_reorder_buffer dut (.clk(clk), .reset(reset), .rob(bus));

`ifdef RISCV_ROB_SAME_CYCLE_COMMIT_EN
    localparam bit SAME = 1'b1;
`else
    localparam bit SAME = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: program-order queue of in-flight instructions.
    typedef struct {
        logic [3:0]  slot;
        bit          wen;
        logic [4:0]  preg;
        bit          fin;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    int          m_tail;
    logic [31:0] m_data [16];
    bit          m_known [16];

    typedef struct {
        bit          av;
        logic [4:0]  ap;
        bit          fv;
        logic [3:0]  fs;
        logic [31:0] fd;
        bit          e_rdy;
        logic [3:0]  e_resp;
        bit          e_cw;
        logic [3:0]  e_slot;
        logic [4:0]  e_waddr;
        logic [31:0] e_data;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit av, input bit aw, input logic [4:0] ap,
                          input bit fv, input logic [3:0] fs, input logic [31:0] fd);
        bus.rob_alloc_req_val  = av;
        bus.rob_alloc_req_wen  = aw;
        bus.rob_alloc_req_preg = ap;
        bus.rob_fill_val       = fv;
        bus.rob_fill_slot      = fs;
        bus.rob_fill_data      = fd;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic model_check();
        bit          cw;
        logic [31:0] cd;
        ent_t        h;
        cw = 1'b0;
        cd = 32'd0;
        h.slot = 4'd0; h.wen = 1'b0; h.preg = 5'd0; h.fin = 1'b0; h.data = 32'd0;
        if (mq.size() > 0) begin
            h = mq[0];
            if (h.fin) begin
                cw = 1'b1;
                cd = h.data;
            end
            if (SAME && bus.rob_fill_val && bus.rob_fill_slot == h.slot) begin
                cw = 1'b1;
                cd = bus.rob_fill_data;
            end
        end
        chk("m_rdy", bus.rob_alloc_req_rdy, (mq.size() != 16));
        chk("m_resp_slot", bus.rob_alloc_resp_slot, m_tail);
        chk("m_commit_wen", bus.rob_commit_wen, cw);
        chk("m_commit_slot", bus.rob_commit_slot, cw ? h.slot : 4'd0);
        chk("m_rf_wen", bus.rob_commit_rf_wen, cw && h.wen);
        chk("m_waddr", bus.rob_commit_rf_waddr, cw ? h.preg : 5'd0);
        chk("m_commit_data", bus.rob_commit_data, cw ? cd : 32'd0);
        if (m_known[bus.rob_src0_slot]) chk("m_src0", bus.rob_src0_data, m_data[bus.rob_src0_slot]);
        if (m_known[bus.rob_src1_slot]) chk("m_src1", bus.rob_src1_data, m_data[bus.rob_src1_slot]);
    endtask

    task automatic model_update();
        bit   alloc_ok;
        bit   cw;
        ent_t e;
        alloc_ok = bus.rob_alloc_req_val && (mq.size() != 16);
        cw = (mq.size() > 0) &&
             (mq[0].fin || (SAME && bus.rob_fill_val && bus.rob_fill_slot == mq[0].slot));
        if (bus.rob_fill_val) begin
            foreach (mq[i]) begin
                if (mq[i].slot == bus.rob_fill_slot) begin
                    mq[i].fin  = 1'b1;
                    mq[i].data = bus.rob_fill_data;
                    m_data[bus.rob_fill_slot]  = bus.rob_fill_data;
                    m_known[bus.rob_fill_slot] = 1'b1;
                end
            end
        end
        if (cw) void'(mq.pop_front());
        if (alloc_ok) begin
            e.slot = m_tail[3:0];
            e.wen  = bus.rob_alloc_req_wen;
            e.preg = bus.rob_alloc_req_preg;
            e.fin  = 1'b0;
            e.data = 32'd0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    // Called in the low phase, with inputs already settled.
    task automatic finish_cycle();
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cycle();
        #1;
        finish_cycle();
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            set_in($urandom_range(1), $urandom_range(1), 5'($urandom), $urandom_range(1),
                   4'($urandom), $urandom);
            #1;
            chk("rst_rdy", bus.rob_alloc_req_rdy, 1'b1);
            chk("rst_resp_slot", bus.rob_alloc_resp_slot, 4'd0);
            chk("rst_commit_wen", bus.rob_commit_wen, 1'b0);
            chk("rst_rf_wen", bus.rob_commit_rf_wen, 1'b0);
            chk("rst_commit_slot", bus.rob_commit_slot, 4'd0);
            chk("rst_waddr", bus.rob_commit_rf_waddr, 5'd0);
            chk("rst_commit_data", bus.rob_commit_data, 32'd0);
            @(negedge clk);
        end
        idle();
        mq.delete();
        m_tail = 0;
        for (int s = 0; s < 16; s++) m_known[s] = 1'b0;
        reset = 1'b1;
    endtask

    function automatic vec_t mkv(input bit av, input logic [4:0] ap, input bit fv,
                                 input logic [3:0] fs, input logic [31:0] fd,
                                 input logic [3:0] e_resp, input bit e_cw,
                                 input logic [3:0] e_slot, input logic [4:0] e_waddr,
                                 input logic [31:0] e_data);
        vec_t v;
        v.av = av; v.ap = ap; v.fv = fv; v.fs = fs; v.fd = fd;
        v.e_rdy = 1'b1; v.e_resp = e_resp; v.e_cw = e_cw;
        v.e_slot = e_slot; v.e_waddr = e_waddr; v.e_data = e_data;
        return v;
    endfunction

    initial begin
        // In-order commit vectors. They start from an empty buffer just
        // after reset.
        tbl[0] = mkv(1, 5'd5, 0, 4'd0, 32'h0,  4'd0, 0, 4'd0, 5'd0, 32'h0);
        tbl[1] = mkv(1, 5'd6, 0, 4'd0, 32'h0,  4'd1, 0, 4'd0, 5'd0, 32'h0);
        tbl[2] = mkv(1, 5'd7, 0, 4'd0, 32'h0,  4'd2, 0, 4'd0, 5'd0, 32'h0);
        tbl[3] = mkv(0, 5'd0, 1, 4'd2, 32'h33, 4'd3, 0, 4'd0, 5'd0, 32'h0);
        tbl[4] = mkv(0, 5'd0, 1, 4'd1, 32'h22, 4'd3, 0, 4'd0, 5'd0, 32'h0);
        tbl[5] = mkv(0, 5'd0, 1, 4'd0, 32'h11, 4'd3, SAME, 4'd0,
                     SAME ? 5'd5 : 5'd0, SAME ? 32'h11 : 32'h0);
        tbl[6] = mkv(0, 5'd0, 0, 4'd0, 32'h0,  4'd3, 1, SAME ? 4'd1 : 4'd0,
                     SAME ? 5'd6 : 5'd5, SAME ? 32'h22 : 32'h11);
        tbl[7] = mkv(0, 5'd0, 0, 4'd0, 32'h0,  4'd3, 1, SAME ? 4'd2 : 4'd1,
                     SAME ? 5'd7 : 5'd6, SAME ? 32'h33 : 32'h22);
        tbl[8] = mkv(0, 5'd0, 0, 4'd0, 32'h0,  4'd3, !SAME, SAME ? 4'd0 : 4'd2,
                     SAME ? 5'd0 : 5'd7, SAME ? 32'h0 : 32'h33);
        tbl[9] = mkv(0, 5'd0, 0, 4'd0, 32'h0,  4'd3, 0, 4'd0, 5'd0, 32'h0);

        idle();
        bus.rob_src0_slot = 4'd0;
        bus.rob_src1_slot = 4'd0;
        @(negedge clk);
        do_reset(3);

        // Table-driven in-order commit.
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].av, 1'b1, tbl[i].ap, tbl[i].fv, tbl[i].fs, tbl[i].fd);
            #1;
            chk("tbl_rdy", bus.rob_alloc_req_rdy, tbl[i].e_rdy);
            chk("tbl_resp_slot", bus.rob_alloc_resp_slot, tbl[i].e_resp);
            chk("tbl_commit_wen", bus.rob_commit_wen, tbl[i].e_cw);
            chk("tbl_commit_slot", bus.rob_commit_slot, tbl[i].e_slot);
            chk("tbl_waddr", bus.rob_commit_rf_waddr, tbl[i].e_waddr);
            chk("tbl_commit_data", bus.rob_commit_data, tbl[i].e_data);
            finish_cycle();
        end

        // Full and wrap behaviour.
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, $urandom_range(1), 5'(i), 1'b0, 4'd0, 32'd0);
            #1;
            chk("full_resp_slot", bus.rob_alloc_resp_slot, i);
            finish_cycle();
        end
        idle();
        #1;
        chk("full_rdy_low", bus.rob_alloc_req_rdy, 1'b0);
        finish_cycle();
        set_in(1'b1, 1'b1, 5'd31, 1'b0, 4'd0, 32'd0);
        #1;
        chk("full_alloc_ignored_rdy", bus.rob_alloc_req_rdy, 1'b0);
        finish_cycle();
        set_in(1'b0, 1'b0, 5'd0, 1'b1, 4'd0, 32'hA0);
        #1;
        chk("full_fill_cw", bus.rob_commit_wen, SAME);
        chk("full_fill_rdy", bus.rob_alloc_req_rdy, 1'b0);
        finish_cycle();
        idle();
        #1;
        chk("full_after_rdy", bus.rob_alloc_req_rdy, SAME);
        chk("full_after_cw", bus.rob_commit_wen, !SAME);
        finish_cycle();
        set_in(1'b1, 1'b1, 5'd1, 1'b0, 4'd0, 32'd0);
        #1;
        chk("wrap_rdy", bus.rob_alloc_req_rdy, 1'b1);
        chk("wrap_resp_slot", bus.rob_alloc_resp_slot, 4'd0);
        finish_cycle();

        // Alloc, head fill and commit in one cycle at count 8.
        do_reset(1);
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 1'b1, 5'(i), 1'b0, 4'd0, 32'd0);
            cycle();
        end
`ifdef RISCV_ROB_SAME_CYCLE_COMMIT_EN
        set_in(1'b1, 1'b1, 5'd7, 1'b0, 4'd0, 32'd0);
        cycle();
        set_in(1'b1, 1'b1, 5'd8, 1'b1, 4'd0, 32'h71);
        #1;
        chk("sim_commit_data", bus.rob_commit_data, 32'h71);
`else
        set_in(1'b1, 1'b1, 5'd7, 1'b1, 4'd0, 32'h70);
        cycle();
        set_in(1'b1, 1'b1, 5'd8, 1'b1, 4'd0, 32'h71);
        #1;
        chk("sim_commit_data", bus.rob_commit_data, 32'h70);
`endif
        chk("sim_commit_wen", bus.rob_commit_wen, 1'b1);
        chk("sim_commit_slot", bus.rob_commit_slot, 4'd0);
        finish_cycle();
        idle();
        #1;
        chk("sim_resp_slot", bus.rob_alloc_resp_slot, 4'd9);
        finish_cycle();
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, 1'b1, 5'd9, 1'b0, 4'd0, 32'd0);
            #1;
            chk("sim_room_rdy", bus.rob_alloc_req_rdy, 1'b1);
            finish_cycle();
        end
        idle();
        #1;
        chk("sim_full_rdy", bus.rob_alloc_req_rdy, 1'b0);
        finish_cycle();
        set_in(1'b0, 1'b0, 5'd0, 1'b1, 4'd1, 32'h81);
        #1;
        chk("sim_head1_cw", bus.rob_commit_wen, SAME);
        chk("sim_head1_slot", bus.rob_commit_slot, SAME ? 4'd1 : 4'd0);
        finish_cycle();
        idle();
        #1;
        chk("sim_head1_cw_next", bus.rob_commit_wen, !SAME);
        chk("sim_head1_slot_next", bus.rob_commit_slot, SAME ? 4'd0 : 4'd1);
        finish_cycle();

        // Non-writing instruction and bypass read.
        do_reset(1);
        set_in(1'b1, 1'b1, 5'd3, 1'b0, 4'd0, 32'd0);
        cycle();
        set_in(1'b1, 1'b0, 5'd9, 1'b0, 4'd0, 32'd0);
        cycle();
        bus.rob_src0_slot = 4'd1;
        set_in(1'b0, 1'b0, 5'd0, 1'b1, 4'd1, 32'hDEAD);
        cycle();
        idle();
        #1;
        chk("byp_src0", bus.rob_src0_data, 32'hDEAD);
        chk("byp_no_commit", bus.rob_commit_wen, 1'b0);
        finish_cycle();
        set_in(1'b0, 1'b0, 5'd0, 1'b1, 4'd0, 32'h1234);
        #1;
        chk("nw_head_cw", bus.rob_commit_wen, SAME);
        finish_cycle();
        idle();
`ifndef RISCV_ROB_SAME_CYCLE_COMMIT_EN
        cycle();
`endif
        #1;
        chk("nw_commit_wen", bus.rob_commit_wen, 1'b1);
        chk("nw_commit_slot", bus.rob_commit_slot, 4'd1);
        chk("nw_rf_wen", bus.rob_commit_rf_wen, 1'b0);
        chk("nw_waddr", bus.rob_commit_rf_waddr, 5'd9);
        chk("nw_commit_data", bus.rob_commit_data, 32'hDEAD);
        finish_cycle();

        // Head fill timing, then a fill to an invalid slot.
        do_reset(1);
        set_in(1'b1, 1'b1, 5'd4, 1'b0, 4'd0, 32'd0);
        cycle();
        set_in(1'b0, 1'b0, 5'd0, 1'b1, 4'd0, 32'hBEEF);
        #1;
        chk("mac_cw_now", bus.rob_commit_wen, SAME);
        chk("mac_data_now", bus.rob_commit_data, SAME ? 32'hBEEF : 32'h0);
        finish_cycle();
        idle();
        #1;
        chk("mac_cw_next", bus.rob_commit_wen, !SAME);
        chk("mac_data_next", bus.rob_commit_data, SAME ? 32'h0 : 32'hBEEF);
        finish_cycle();
        set_in(1'b0, 1'b0, 5'd0, 1'b1, 4'd5, 32'h55);
        #1;
        chk("inv_fill_cw", bus.rob_commit_wen, 1'b0);
        finish_cycle();
        idle();
        #1;
        chk("inv_after_cw", bus.rob_commit_wen, 1'b0);
        chk("inv_after_resp", bus.rob_alloc_resp_slot, 4'd1);
        chk("inv_after_rdy", bus.rob_alloc_req_rdy, 1'b1);
        finish_cycle();

        // Randomized traffic against the model, with a mid-run reset.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] fs;
            if (n == 300) do_reset(2);
            if (mq.size() > 0 && $urandom_range(3) != 0)
                fs = mq[$urandom_range(mq.size() - 1)].slot;
            else
                fs = 4'($urandom);
            set_in($urandom_range(3) != 0, $urandom_range(1), 5'($urandom),
                   $urandom_range(2) != 0, fs, $urandom);
            bus.rob_src0_slot = 4'($urandom);
            bus.rob_src1_slot = 4'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
